// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer
// Description : Serial-in, parallel-out receiver. It samples one bit on each
//               serial_valid strobe and aligns words on frame_start. Each
//               completed WIDTH-bit word appears on a registered parallel
//               output with a valid/ready handshake. The sticky overrun flag
//               records any word dropped because the output was still full.
// Ports       : clk, reset_n (async, active-low)
//               serial_in, serial_valid, frame_start  - serial side
//               parallel_out, out_valid, out_ready     - word side
//               overrun, clear_overrun                 - error flag
//               bit_count                              - bits held in the current word
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     serial_in,
    input  logic                     serial_valid,
    input  logic                     frame_start,
    output logic [WIDTH-1:0]         parallel_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overrun,
    input  logic                     clear_overrun,
    output logic [$clog2(WIDTH)-1:0] bit_count
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_shifted;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;
    logic             w_capture;
    logic             w_complete;
    logic [WIDTH-1:0] r_pout;
    logic             r_out_valid;
    logic             r_overrun;

    // Shift direction fixes which output bit the first received bit lands in.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shreg_shifted = {r_shreg[WIDTH-2:0], serial_in};
        end else begin : g_lsb_first
            assign w_shreg_shifted = {serial_in, r_shreg[WIDTH-1:1]};
        end
    endgenerate

    // Next-state, capture and completion decode.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_complete   = 1'b0;
        w_count_next = r_count;
        case (r_state)
            S_IDLE: begin
                // Unaligned bits are dropped until a frame marker arrives.
                if (serial_valid && frame_start) begin
                    w_state_next = S_SHIFT;
                    w_capture    = 1'b1;
                    w_count_next = CW'(1);
                end
            end
            S_SHIFT: begin
                if (serial_valid) begin
                    w_capture = 1'b1;
                    if (frame_start) begin
                        // Resync: this bit restarts the word as bit 0.
                        w_count_next = CW'(1);
                    end else if (r_count == c_LAST) begin
                        w_complete   = 1'b1;
                        w_count_next = '0;
                    end else begin
                        w_count_next = r_count + CW'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_capture) begin
                r_shreg <= w_shreg_shifted;
            end
        end
    end

    // Output word register and handshake. A completing word loads only when
    // the output slot is empty or being drained on this same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pout      <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_complete && (!r_out_valid || out_ready)) begin
                r_pout      <= w_shreg_shifted;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            // Set has priority over clear so a drop is never lost.
            if (w_complete && r_out_valid && !out_ready) begin
                r_overrun <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign parallel_out = r_pout;
    assign out_valid    = r_out_valid;
    assign overrun      = r_overrun;
    assign bit_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deserializer
// Description : Directed self-checking bench for sipo_deserializer. Two
//               instances share the same stimulus: one MSB-first and one
//               LSB-first, both with WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;

    logic       clk;
    logic       reset_n;
    logic       serial_in;
    logic       serial_valid;
    logic       frame_start;
    logic       out_ready;
    logic       clear_overrun;
    logic [3:0] pout_m;
    logic       ov_m;
    logic       orun_m;
    logic [1:0] cnt_m;
    logic [3:0] pout_l;
    logic       ov_l;
    logic       orun_l;
    logic [1:0] cnt_l;

    int checks;
    int failures;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk           (clk),
        .reset_n       (reset_n),
        .serial_in     (serial_in),
        .serial_valid  (serial_valid),
        .frame_start   (frame_start),
        .parallel_out  (pout_m),
        .out_valid     (ov_m),
        .out_ready     (out_ready),
        .overrun       (orun_m),
        .clear_overrun (clear_overrun),
        .bit_count     (cnt_m)
    );

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk           (clk),
        .reset_n       (reset_n),
        .serial_in     (serial_in),
        .serial_valid  (serial_valid),
        .frame_start   (frame_start),
        .parallel_out  (pout_l),
        .out_valid     (ov_l),
        .out_ready     (out_ready),
        .overrun       (orun_l),
        .clear_overrun (clear_overrun),
        .bit_count     (cnt_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One strobed bit; returns 1 time unit after the capturing edge.
    task automatic send_bit(input logic b, input logic fs);
        serial_in    = b;
        frame_start  = fs;
        serial_valid = 1'b1;
        @(posedge clk);
        #1;
        serial_valid = 1'b0;
        frame_start  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #12;
        reset_n = 1'b1;
        idle_cycle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pout_m !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pout actual=%b expected=0000", pout_m);
        end
        checks++;
        if (ov_m !== 1'b0 || orun_m !== 1'b0 || cnt_m !== 2'd0) begin
            failures++;
            $display("FAIL reset_flags actual valid=%b overrun=%b count=%0d expected 0/0/0",
                     ov_m, orun_m, cnt_m);
        end
    endtask

    task automatic test_single_word();
        out_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        checks++;
        if (cnt_m !== 2'd1) begin
            failures++;
            $display("FAIL single_count1 actual=%0d expected=1", cnt_m);
        end
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++;
        if (pout_m !== 4'b1011 || ov_m !== 1'b1 || cnt_m !== 2'd0) begin
            failures++;
            $display("FAIL single_word actual=%b valid=%b count=%0d expected=1011 valid=1 count=0",
                     pout_m, ov_m, cnt_m);
        end
        checks++;
        if (pout_l !== 4'b1101) begin
            failures++;
            $display("FAIL lsb_first_word actual=%b expected=1101", pout_l);
        end
        idle_cycle();
        checks++;
        if (ov_m !== 1'b0) begin
            failures++;
            $display("FAIL single_drain actual valid=%b expected=0", ov_m);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        bits      = 8'b1011_0101;
        out_ready = 1'b1;
        for (int i = 7; i >= 4; i--) send_bit(bits[i], (i == 7));
        checks++;
        if (pout_m !== 4'b1011 || ov_m !== 1'b1) begin
            failures++;
            $display("FAIL b2b_word1 actual=%b valid=%b expected=1011 valid=1", pout_m, ov_m);
        end
        for (int i = 3; i >= 0; i--) send_bit(bits[i], 1'b0);
        checks++;
        if (pout_m !== 4'b0101 || ov_m !== 1'b1) begin
            failures++;
            $display("FAIL b2b_word2 actual=%b valid=%b expected=0101 valid=1", pout_m, ov_m);
        end
        checks++;
        if (pout_l !== 4'b1010) begin
            failures++;
            $display("FAIL b2b_lsb_word2 actual=%b expected=1010", pout_l);
        end
        idle_cycle();
    endtask

    task automatic test_overrun();
        logic [7:0] bits;
        bits      = 8'b1011_0110;
        out_ready = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit(bits[i], (i == 7));
        checks++;
        if (pout_m !== 4'b1011 || ov_m !== 1'b1 || orun_m !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set actual=%b valid=%b overrun=%b expected=1011 1 1",
                     pout_m, ov_m, orun_m);
        end
        clear_overrun = 1'b1;
        idle_cycle();
        clear_overrun = 1'b0;
        checks++;
        if (orun_m !== 1'b0 || ov_m !== 1'b1 || pout_m !== 4'b1011) begin
            failures++;
            $display("FAIL overrun_clear actual overrun=%b valid=%b pout=%b expected 0 1 1011",
                     orun_m, ov_m, pout_m);
        end
    endtask

    // Word completes on the same edge the held word is accepted.
    task automatic test_accept_and_complete();
        out_ready = 1'b0;
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        out_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        checks++;
        if (pout_m !== 4'b0111 || ov_m !== 1'b1 || orun_m !== 1'b0) begin
            failures++;
            $display("FAIL accept_complete actual=%b valid=%b overrun=%b expected=0111 1 0",
                     pout_m, ov_m, orun_m);
        end
        // Overrun set and clear on the same edge: set wins.
        out_ready = 1'b0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        clear_overrun = 1'b1;
        send_bit(1'b0, 1'b0);
        clear_overrun = 1'b0;
        checks++;
        if (orun_m !== 1'b1 || pout_m !== 4'b0111) begin
            failures++;
            $display("FAIL set_beats_clear actual overrun=%b pout=%b expected 1 0111",
                     orun_m, pout_m);
        end
        clear_overrun = 1'b1;
        out_ready     = 1'b1;
        idle_cycle();
        clear_overrun = 1'b0;
    endtask

    task automatic test_ignore_and_resync();
        do_reset();
        out_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++;
        if (cnt_m !== 2'd0 || ov_m !== 1'b0) begin
            failures++;
            $display("FAIL ignore_unaligned actual count=%0d valid=%b expected 0 0", cnt_m, ov_m);
        end
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        checks++;
        if (pout_m !== 4'b0010 || ov_m !== 1'b1) begin
            failures++;
            $display("FAIL aligned_word actual=%b valid=%b expected=0010 1", pout_m, ov_m);
        end
        // Resync in SHIFT: partial 1,1 is discarded.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        checks++;
        if (cnt_m !== 2'd1 || orun_m !== 1'b0) begin
            failures++;
            $display("FAIL resync_count actual count=%0d overrun=%b expected 1 0", cnt_m, orun_m);
        end
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++;
        if (pout_m !== 4'b1001 || ov_m !== 1'b1) begin
            failures++;
            $display("FAIL resync_word actual=%b valid=%b expected=1001 1", pout_m, ov_m);
        end
        idle_cycle();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ov_m !== 1'b0 || cnt_m !== 2'd0 || pout_m !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset actual valid=%b count=%0d pout=%b expected 0 0 0000",
                     ov_m, cnt_m, pout_m);
        end
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        idle_cycle();
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        checks++;
        if (ov_m !== 1'b0 || cnt_m !== 2'd0) begin
            failures++;
            $display("FAIL post_reset_needs_fs actual valid=%b count=%0d expected 0 0", ov_m, cnt_m);
        end
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        checks++;
        if (pout_m !== 4'b0110 || ov_m !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_word actual=%b valid=%b expected=0110 1", pout_m, ov_m);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset_n       = 1'b1;
        serial_in     = 1'b0;
        serial_valid  = 1'b0;
        frame_start   = 1'b0;
        out_ready     = 1'b0;
        clear_overrun = 1'b0;
        #3;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overrun();
        test_accept_and_complete();
        test_ignore_and_resync();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in, parallel-out receiver that reassembles words produced by the team's PISO shift register. The block samples one bit per `serial_valid` strobe and aligns words on a `frame_start` marker. Each completed WIDTH-bit word is presented on a registered parallel output with a valid/ready handshake. It sits at the receive end of the serial link and feeds word-oriented logic downstream.

Parameters:
WIDTH, 4, word length in bits; legal range 2..32.
MSB_FIRST, 1, 1 = first received bit lands in `parallel_out[WIDTH-1]`; 0 = first bit lands in `parallel_out[0]`.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
serial_in  input  1  serial data bit, sampled only when `serial_valid`=1.
serial_valid  input  1  bit strobe; one bit is consumed per cycle it is high.
frame_start  input  1  marks the current bit as bit 0 of a new word; qualified by `serial_valid`.
parallel_out  output  WIDTH  last completed word, held stable while `out_valid`=1.
out_valid  output  1  `parallel_out` holds an unconsumed word.
out_ready  input  1  downstream accepts the word when `out_valid` & `out_ready`.
overrun  output  1  sticky error: a completed word was dropped because the output was still full.
clear_overrun  input  1  synchronous clear of `overrun`.
bit_count  output  clog2(WIDTH)  number of bits already captured in the current word.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (`reset_n`=0): takes effect immediately, independent of `clk`.
  - State = IDLE; shift register, `parallel_out` and `bit_count` = 0.
  - `out_valid` = 0, `overrun` = 0.
  - Reset mid-word discards the partial word.
- States:
  - IDLE: waits for alignment. Bits with `frame_start`=0 are ignored and `bit_count` stays 0.
    - IDLE -> SHIFT on `serial_valid` & `frame_start`. That bit is captured as bit 0 and `bit_count` becomes 1.
  - SHIFT: each `serial_valid` cycle captures `serial_in` and increments `bit_count`.
    - Capture into the shift register with MSB_FIRST=1: `shreg <= {shreg[WIDTH-2:0], serial_in}`.
    - With MSB_FIRST=0: `shreg <= {serial_in, shreg[WIDTH-1:1]}`.
  - A cycle with `serial_valid`=0 holds all state; gaps between bits are unbounded.
- Word completion: occurs on the edge that captures bit WIDTH-1.
  - The assembled word, including that bit, is transferred to `parallel_out`.
  - `out_valid` is 1 after that same edge (zero extra latency).
  - `bit_count` returns to 0 and the block remains in SHIFT, so back-to-back words need no further `frame_start`.
- Resync: `frame_start` & `serial_valid` while in SHIFT with `bit_count`≠0 discards the partial word.
  - The current bit becomes bit 0 and `bit_count` = 1.
  - This is not an error; `overrun` is unaffected.
- Handshake:
  - `out_valid` falls on the edge where `out_valid` & `out_ready` = 1, unless a new word completes on that same edge.
  - `parallel_out` does not change while `out_valid`=1 and no transfer occurs.
- Simultaneous accept and completion: the new word loads into `parallel_out`, `out_valid` stays 1, and `overrun` is not set.
- Overrun: a word completes while `out_valid`=1 and `out_ready`=0.
  - The new word is dropped and `parallel_out` keeps the old word.
  - `overrun` is set to 1 and held until `clear_overrun`.
  - If set and clear coincide on the same edge, set wins.
- `out_ready` with `out_valid`=0 has no effect.

Test Plan:
- Reset, then with WIDTH=4, MSB_FIRST=1, `out_ready`=1: send 1,0,1,1 (`frame_start` on the first bit) -> `parallel_out`=4'b1011 and `out_valid`=1 after the 4th bit edge, for one cycle.
- Back-to-back words 1011 then 0101, with `frame_start` only on the first bit -> outputs 4'b1011 then 4'b0101; no bit lost.
- `out_ready`=0: send words 1011 then 0110 -> `parallel_out` stays 4'b1011 and `overrun`=1. Then assert `clear_overrun` -> `overrun`=0.
- Bits before any `frame_start` are ignored. Then send 1,1, assert `frame_start` on the next bit, and send 0,0,1,0 -> `parallel_out`=4'b0010.
- MSB_FIRST=0: send 1,0,1,1 -> `parallel_out`=4'b1101.
- Drop `reset_n` low asynchronously after 2 bits of a word -> `out_valid`=0, `bit_count`=0 and `parallel_out`=0 immediately; the next word needs a new `frame_start`.
